// File: rtl/image_pkg.sv
// Shared pixel/window types and filter mode encoding
// for the 3x3 convolution path.
package image_pkg;
    localparam int DATA_WIDTH   = 12;
    localparam int PIXEL_LENGTH = DATA_WIDTH;
    localparam int SUM_W        = 15;
    localparam int MAG_W        = 16;

    typedef logic [DATA_WIDTH-1:0] pix_t;
    typedef pix_t [2:0][2:0]       window_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    localparam pix_t PIX_MAX = '1;

    typedef enum logic [1:0] {
        FM_IDENT,
        FM_GX,
        FM_GY,
        FM_MAG
    } filt_mode_e;

    function automatic sum_t sdiff(pix_t a, pix_t b);
        sum_t sa;
        sum_t sb;
        sa = {3'b000, a};
        sb = {3'b000, b};
        return sa - sb;
    endfunction
endpackage

// File: rtl/conv3x3_filter_if.sv
// Window-in / pixel-out bundle between the window stage,
// the filter and the display path.
interface conv3x3_filter_if;
    import image_pkg::*;

    window_t    data_matrix;
    logic       valid_in;
    logic       edge_in;
    filt_mode_e mode;
    pix_t       pixel_out;
    logic       valid_out;
    logic       edge_out;

    modport master (
        output data_matrix, valid_in, edge_in, mode,
        input  pixel_out, valid_out, edge_out
    );

    modport slave (
        input  data_matrix, valid_in, edge_in, mode,
        output pixel_out, valid_out, edge_out
    );
endinterface

// File: rtl/conv_abs_sat.sv
// Result select: abs of the gradients, optional sum,
// right shift and clamp to the pixel range.
module conv_abs_sat
    import image_pkg::*;
#(
    parameter int OUT_SHIFT = 0
) (
    input  filt_mode_e mode,
    input  pix_t       centre,
    input  sum_t       gx,
    input  sum_t       gy,
    input  logic       win_ok,
    output pix_t       pix
);
    logic [SUM_W-1:0] gxa;
    logic [SUM_W-1:0] gya;
    logic [MAG_W-1:0] ax;
    logic [MAG_W-1:0] ay;
    logic [MAG_W-1:0] sel;
    logic [MAG_W-1:0] shf;

    always_comb begin
        gxa = gx[SUM_W-1] ? SUM_W'(-gx) : SUM_W'(gx);
        gya = gy[SUM_W-1] ? SUM_W'(-gy) : SUM_W'(gy);
        ax  = {1'b0, gxa};
        ay  = {1'b0, gya};
        sel = '0;
        unique case (mode)
            FM_IDENT: sel = MAG_W'(centre);
            FM_GX:    sel = ax;
            FM_GY:    sel = ay;
            FM_MAG:   sel = ax + ay;
            default:  sel = '0;
        endcase
        // windows straddling a line break only pass the centre pixel
        if (!win_ok && mode != FM_IDENT)
            sel = '0;
        shf = sel >> OUT_SHIFT;
        pix = (shf > MAG_W'(PIX_MAX)) ? PIX_MAX : shf[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/conv3x3_filter.sv
// Three-stage 3x3 filter: capture, Sobel sums, select/clamp.
// Fill counter suppresses windows that wrap across lines.
module conv3x3_filter
    import image_pkg::*;
#(
    parameter int OUT_SHIFT = 0
) (
    input logic             clk,
    input logic             rst,
    conv3x3_filter_if.slave bus
);
    logic [1:0] fill;
    logic [1:0] fill_next;
    logic       win_ok;

    window_t    win_s1;
    filt_mode_e mode_s1;
    logic       edge_s1;
    logic       ok_s1;
    logic       v_s1;

    sum_t       gx;
    sum_t       gy;
    sum_t       gx_s2;
    sum_t       gy_s2;
    pix_t       centre_s2;
    filt_mode_e mode_s2;
    logic       edge_s2;
    logic       ok_s2;
    logic       v_s2;

    pix_t       pix_d;
    pix_t       pix_q;
    logic       valid_q;
    logic       edge_q;

    always_comb begin
        fill_next = 2'd1;
        if (!bus.edge_in)
            fill_next = (fill == 2'd3) ? 2'd3 : fill + 2'd1;
        win_ok = (fill_next == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill    <= '0;
            win_s1  <= '0;
            mode_s1 <= FM_IDENT;
            edge_s1 <= 1'b0;
            ok_s1   <= 1'b0;
            v_s1    <= 1'b0;
        end else begin
            v_s1    <= bus.valid_in;
            edge_s1 <= bus.valid_in & bus.edge_in;
            if (bus.valid_in) begin
                fill    <= fill_next;
                win_s1  <= bus.data_matrix;
                mode_s1 <= bus.mode;
                ok_s1   <= win_ok;
            end
        end
    end

    // col 0 minus col 2 across rows, row 0 minus row 2 across cols
    always_comb begin
        gx = sdiff(win_s1[0][0], win_s1[0][2])
           + (sdiff(win_s1[1][0], win_s1[1][2]) <<< 1)
           + sdiff(win_s1[2][0], win_s1[2][2]);
        gy = sdiff(win_s1[0][0], win_s1[2][0])
           + (sdiff(win_s1[0][1], win_s1[2][1]) <<< 1)
           + sdiff(win_s1[0][2], win_s1[2][2]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_s2     <= '0;
            gy_s2     <= '0;
            centre_s2 <= '0;
            mode_s2   <= FM_IDENT;
            edge_s2   <= 1'b0;
            ok_s2     <= 1'b0;
            v_s2      <= 1'b0;
        end else begin
            gx_s2     <= gx;
            gy_s2     <= gy;
            centre_s2 <= win_s1[1][1];
            mode_s2   <= mode_s1;
            edge_s2   <= edge_s1;
            ok_s2     <= ok_s1;
            v_s2      <= v_s1;
        end
    end

    conv_abs_sat #(
        .OUT_SHIFT (OUT_SHIFT)
    ) u_sat (
        .mode   (mode_s2),
        .centre (centre_s2),
        .gx     (gx_s2),
        .gy     (gy_s2),
        .win_ok (ok_s2),
        .pix    (pix_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_q   <= '0;
            valid_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            valid_q <= v_s2;
            edge_q  <= edge_s2;
        end
    end

    assign bus.pixel_out = pix_q;
    assign bus.valid_out = valid_q;
    assign bus.edge_out  = edge_q;
endmodule
